regalu_ctrl: RTL
================

// Module: regalu_ctrl
// PURPOSE
//  Instruction sequencer driving the control/data port of reg_alu, the initiator end of that interface.
//  Accepts 16-bit instructions on a valid/ready handshake, decodes them, then drives sel/wr/op/addresses/d_in.
//  Also latches the ALU carry and counts retired instructions.
//  Sits between an instruction source (ROM walker or bench) and reg_alu.
// PARAMETERS
//  DATA_W  16  reg_alu data width; instruction width; d_in width
//  ADDR_W  3   register address width (8 registers)
//  OP_W    3   reg_alu op code width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  instr        in   DATA_W  instruction word
//  instr_valid  in   1       instr is valid
//  instr_ready  out  1       controller can accept; transfer when valid&&ready at posedge clk
//  resume       in   1       leave HALTED state
//  alu_cout     in   1       cout from reg_alu
//  sel          out  1       1 = write ALU result, 0 = write d_in
//  wr           out  1       register-file write strobe
//  op           out  OP_W    ALU operation
//  rd_addr_a    out  ADDR_W  ALU operand A address
//  rd_addr_b    out  ADDR_W  ALU operand B address
//  wr_addr      out  ADDR_W  destination register address
//  d_in         out  DATA_W  immediate write data
//  carry_flag   out  1       carry from the last retired ALU instruction
//  halted       out  1       in HALTED state
//  retired      out  16      retired-instruction count, wraps 16'hFFFF->0
// BEHAVIOUR
//  Encoding, class = instr[15:14]:
//   00 ALU: op=[13:11], wr_addr=[10:8], rd_addr_a=[7:5], rd_addr_b=[4:2], [1:0] ignored.
//   01 LDI: wr_addr=[13:11], d_in={5'b0,[10:0]} (zero-extended).
//   10 NOP: no write. 11 HALT.
//  FSM states: IDLE, DECODE, EXEC, HALTED.
//   IDLE: instr_ready=1. valid&&ready at edge E0 registers all fields and goes to DECODE.
//   DECODE (one cycle): addresses, op, sel and d_in driven and stable; wr=0. Next state is EXEC.
//   EXEC (one cycle): wr=1 for ALU/LDI, 0 for NOP. reg_alu writes at edge E2.
//    At E2: retired+=1. For ALU class, carry_flag<=alu_cout. Next state is IDLE, or HALTED for HALT.
//   HALTED: instr_ready=0, halted=1. resume=1 at an edge returns to IDLE; instr is ignored.
//  Throughput: 1 instruction per 3 cycles. instr_ready is low in DECODE, EXEC and HALTED.
//  sel: 1 for ALU class, 0 otherwise. d_in is 0 for ALU class.
//  Between instructions (IDLE, HALTED), op/addresses/sel/d_in hold their last values; wr=0.
//  wr is a registered output, high only in EXEC, and never high on two consecutive cycles.
//  Reset values: state=IDLE, wr=0, sel=0, op=0, all addresses=0, d_in=0, carry_flag=0, halted=0, retired=0.
//   instr_ready=1 after reset release.
//  Reset mid-instruction (DECODE/EXEC): wr drops immediately, asynchronously. No partial write, no retire.
//  HALT retires: it counts in retired, wr=0.
//  Simultaneous resume and instr_valid in HALTED: the instruction is not accepted that cycle.
//  instr is sampled only on the handshake edge; later changes have no effect.
// STRUCTURE
//  Shared package regalu_pkg:
//   class codes CLS_ALU=2'b00, CLS_LDI=2'b01, CLS_NOP=2'b10, CLS_HALT=2'b11;
//   FSM state encoding; field bit positions; reg_alu op code constants (shared with reg_alu).
//  Sub-module regalu_decode: combinational instr -> class/op/addresses/imm.
//  FSM, output registers, carry and retire counter live in regalu_ctrl.
//  Bench instantiates regalu_ctrl driving reg_alu.
// TESTING
//  1 Reset: hold reset 2 cycles -> all outputs 0, instr_ready=1 after release.
//  2 LDI: instr=16'h4813 (LDI r1,0x013) -> DECODE: wr_addr=1, sel=0, d_in=16'h0013.
//     EXEC: wr=1 for exactly one cycle; reg_alu r1 reads 16'h0013; retired=1.
//  3 ALU: after LDI r2 (16'h5007 -> r2=7), instr=16'h2328 (op=100,rd=3,ra=1,rb=2)
//     -> sel=1, op=3'b100, rd_addr_a=1, rd_addr_b=2, wr_addr=3, wr pulse; carry_flag=alu_cout at E2.
//  4 Back-to-back: instr_valid held high with 4 instructions -> accepted every 3rd cycle, retired=4, no wr gap violation.
//  5 HALT: 16'hC000 -> halted=1, instr_ready=0, valid instructions ignored.
//     resume=1 -> IDLE; the next instruction executes normally.
//  6 Reset during EXEC of 16'h2328 -> wr falls before the next edge, r3 unchanged, retired unchanged, state IDLE.
//  7 Counter wrap: preload via 65535 NOPs (or force) -> retired 16'hFFFF->16'h0000.

Source files
------------

// File: rtl/regalu_pkg.sv
// Shared definitions for the reg_alu instruction sequencer: instruction classes,
// FSM states, instruction field positions and reg_alu operation codes.
package regalu_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LDI  = 2'b01,
    CLS_NOP  = 2'b10,
    CLS_HALT = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int CLS_LSB    = 14;
  localparam int ALU_OP_LSB = 11;
  localparam int ALU_WR_LSB = 8;
  localparam int ALU_RA_LSB = 5;
  localparam int ALU_RB_LSB = 2;
  localparam int LDI_WR_LSB = 11;
  localparam int IMM_W      = 11;
  localparam int RETIRE_W   = 16;

  // reg_alu operation codes; cout is the carry (ADD/INC) or borrow (SUB)
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

endpackage

// File: rtl/regalu_decode.sv
// Combinational instruction decoder: splits a 16-bit instruction word into
// class, ALU op, register addresses and the zero-extended LDI immediate.
module regalu_decode
  import regalu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic [DATA_W-1:0] instr_i,
  output cls_e              cls_o,
  output logic [OP_W-1:0]   op_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  output logic [DATA_W-1:0] imm_o
);

  always_comb begin
    cls_o       = cls_e'(instr_i[CLS_LSB +: 2]);
    op_o        = instr_i[ALU_OP_LSB +: OP_W];
    rd_addr_a_o = instr_i[ALU_RA_LSB +: ADDR_W];
    rd_addr_b_o = instr_i[ALU_RB_LSB +: ADDR_W];
    // LDI places its destination where ALU keeps the op field
    wr_addr_o   = (cls_o == CLS_LDI) ? instr_i[LDI_WR_LSB +: ADDR_W]
                                     : instr_i[ALU_WR_LSB +: ADDR_W];
    imm_o       = DATA_W'(instr_i[IMM_W-1:0]);
  end

endmodule

// File: rtl/regalu_ctrl.sv
// Instruction sequencer driving reg_alu: accepts an instruction, spends one
// cycle presenting operands (DECODE), one cycle writing (EXEC), then retires.
module regalu_ctrl
  import regalu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                resume,
  input  logic                alu_cout,
  output logic                sel,
  output logic                wr,
  output logic [OP_W-1:0]     op,
  output logic [ADDR_W-1:0]   rd_addr_a,
  output logic [ADDR_W-1:0]   rd_addr_b,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   d_in,
  output logic                carry_flag,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  cls_e                dec_cls;
  logic [OP_W-1:0]     dec_op;
  logic [ADDR_W-1:0]   dec_wr_addr, dec_ra, dec_rb;
  logic [DATA_W-1:0]   dec_imm;

  state_e              state_q;
  cls_e                cls_q;
  logic                wr_q, sel_q, carry_q, halted_q;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   ra_q, rb_q, wa_q;
  logic [DATA_W-1:0]   din_q;
  logic [RETIRE_W-1:0] retired_q;

  regalu_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_decode (
    .instr_i     (instr),
    .cls_o       (dec_cls),
    .op_o        (dec_op),
    .wr_addr_o   (dec_wr_addr),
    .rd_addr_a_o (dec_ra),
    .rd_addr_b_o (dec_rb),
    .imm_o       (dec_imm)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NOP;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      din_q     <= '0;
      carry_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            cls_q   <= dec_cls;
            state_q <= ST_DECODE;
            // NOP/HALT leave the datapath fields untouched apart from sel
            case (dec_cls)
              CLS_ALU: begin
                sel_q <= 1'b1;
                op_q  <= dec_op;
                ra_q  <= dec_ra;
                rb_q  <= dec_rb;
                wa_q  <= dec_wr_addr;
                din_q <= '0;
              end
              CLS_LDI: begin
                sel_q <= 1'b0;
                wa_q  <= dec_wr_addr;
                din_q <= dec_imm;
              end
              default: sel_q <= 1'b0;
            endcase
          end
        end
        ST_DECODE: begin
          wr_q    <= (cls_q == CLS_ALU) || (cls_q == CLS_LDI);
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          wr_q      <= 1'b0;
          retired_q <= retired_q + RETIRE_W'(1);
          if (cls_q == CLS_ALU) carry_q <= alu_cout;
          if (cls_q == CLS_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            halted_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign wr          = wr_q;
  assign sel         = sel_q;
  assign op          = op_q;
  assign rd_addr_a   = ra_q;
  assign rd_addr_b   = rb_q;
  assign wr_addr     = wa_q;
  assign d_in        = din_q;
  assign carry_flag  = carry_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule
